// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional macro TX_ARB_TIMEOUT_EN adds a start-handshake timeout with a sticky err flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    input  logic                        tx_ready,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        err
);
    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD, START, SEND} state_t;

    state_t                          state;
    logic [ID_W-1:0]                 last;
    logic [ID_W-1:0]                 win;
    logic [ID_W-1:0]                 idx;
    logic                            found;
    logic [NUM_REQ-1:0][DATA_W-1:0]  req_bytes;

    assign req_bytes = req_data;

    // Scan starts just past the last winner and wraps, so the last winner
    // is checked last and a lone requester still gets picked.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            last     <= ID_W'(NUM_REQ - 1);
`ifdef TX_ARB_TIMEOUT_EN
            cnt      <= '0;
            err      <= 1'b0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found && tx_ready) begin
                        grant_id <= win;
                        tx_data  <= req_bytes[win];
                        last     <= win;
                        ack      <= NUM_REQ'(1) << win;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_start <= 1'b1;
`ifdef TX_ARB_TIMEOUT_EN
                    cnt      <= '0;
`endif
                    state    <= START;
                end
                START: begin
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                        state    <= SEND;
                    end
`ifdef TX_ARB_TIMEOUT_EN
                    // Transmitter never took the byte: drop it (already acked).
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        tx_start <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                SEND: begin
                    if (tx_ready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
